kbd_seg_disp: RTL and testbench
===============================

KBD_SEG_DISP -- requirements
Module: kbd_seg_disp

Interface
REQ-001 SHALL have parameter BLANK_IDLE, default 1; when 1, seg0-seg3 are blank while no key is held.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port kbd_data, input, 8 bits: head byte of the ps2_keyboard FIFO.
REQ-005 SHALL have port kbd_ready, input, 1 bit: FIFO non-empty.
REQ-006 SHALL have port kbd_overflow, input, 1 bit: FIFO overflow indication.
REQ-007 SHALL have port kbd_nextdata_n, output, 1 bit: active-low pop strobe to the FIFO.
REQ-008 SHALL have ports seg0 to seg7, output, 8 bits each: active-low digits; bit7=a, bits 6..1=b..g, bit0=dp.
REQ-009 SHALL have port ovf, output, 1 bit: sticky FIFO-overflow flag.

Function
REQ-010 SHALL implement a pop FSM with states IDLE, POP and GAP.
REQ-011 In IDLE with kbd_ready=1 sampled at edge k, SHALL latch kbd_data and go to POP; kbd_nextdata_n SHALL be 0 for exactly cycle k+1.
REQ-012 POP SHALL go to GAP unconditionally; GAP (kbd_nextdata_n=1) SHALL go to IDLE unconditionally, so that ready can update before the next sample.
REQ-013 The latched byte SHALL be processed at edge k+2; seg outputs are registered and SHALL reflect it after edge k+3.
REQ-014 Byte 8'hF0 SHALL set break_pending; byte 8'hE0 SHALL set ext_pending; neither changes the display or the count.
REQ-015 A non-prefix byte with break_pending=1 SHALL clear held when it equals held_code, and SHALL be ignored otherwise.
REQ-016 A non-prefix byte with break_pending=0 SHALL be treated as a make code.
REQ-017 If no key is held, or the make code differs from held_code, SHALL set held=1 and held_code=byte, and SHALL increment count.
REQ-018 A make code equal to held_code while held=1 (typematic repeat) SHALL NOT increment count.
REQ-019 Any non-prefix byte SHALL clear both break_pending and ext_pending.
REQ-020 count SHALL be 8 bits, increment modulo 256 (8'hFF -> 8'h00), and stay unchanged on release.
REQ-021 seg1/seg0 SHALL show held_code as high/low hex nibbles.
REQ-022 seg3/seg2 SHALL show the ASCII hex of held_code; an extended (ext) make or an unmapped code SHALL give ASCII 8'h00.
REQ-023 seg5/seg4 SHALL show count as hex at all times; seg7 and seg6 SHALL be 8'hFF.
REQ-024 When held=0 and BLANK_IDLE=1, seg0-seg3 SHALL be 8'hFF.
REQ-025 Hex digit encodings SHALL include: 0=8'h03, 1=8'h9F, 6=8'h41, A=8'h11, C=8'h63; dp SHALL always be off (1).
REQ-026 ovf SHALL be set on any cycle with kbd_overflow=1 and held until reset.

Reset
REQ-027 With rst=1 at an edge: state SHALL become IDLE, kbd_nextdata_n=1, held=0, held_code=0, count=0, pending flags=0 and ovf=0.
REQ-028 After reset, seg0-seg3=8'hFF (BLANK_IDLE=1), seg4=seg5=8'h03 and seg6=seg7=8'hFF.
REQ-029 Reset asserted in POP or GAP SHALL drop the latched byte unprocessed, with kbd_nextdata_n=1 in the following cycle.

Structure
REQ-030 A shared package kbd_pkg SHALL hold the FSM state enum, the constants BREAK_CODE=8'hF0 and EXT_CODE=8'hE0, and the hex-to-segment function.
REQ-031 One combinational sub-module scancode_ascii SHALL map set-2 scan codes for a-z (lower case) and 0-9 to ASCII, and all other codes to 8'h00.

Verification
REQ-032 Reset, then push 1C -> after edge k+3: seg1=8'h9F, seg0=8'h63, seg3=8'h41, seg2=8'h9F, seg5=8'h03, seg4=8'h9F.
REQ-033 Push 1C,1C,1C (typematic), then F0,1C -> count stays 01; after the release seg0-seg3=8'hFF.
REQ-034 Push 16 (key 1) while 1C is held -> seg1/seg0 show 16, seg3/seg2 show 31, count=02; then F0,1C -> ignored, display still shows 16.
REQ-035 Push E0,75 -> seg1/seg0 show 75, seg3=seg2=8'h03, count increments; then E0,F0,75 -> display blanks.
REQ-036 Keep kbd_ready high for 4 bytes -> each kbd_nextdata_n low pulse is exactly 1 cycle, with pulses 3 cycles apart; assert rst during a POP -> that byte is not counted.
REQ-037 Pulse kbd_overflow for 1 cycle -> ovf=1 until rst; 256 distinct alternating make codes -> count wraps to 8'h00.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and helpers for the PS/2 keyboard seven-segment display block.
// Holds the pop FSM states, the set-2 prefix bytes and the active-low hex-digit encoder.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } pop_state_e;

  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE   = 8'hE0;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] SEG_ZERO   = 8'h03;

  // Bit 7 = segment a down to bit 1 = segment g; bit 0 (dp) is held off.
  function automatic logic [7:0] hex2seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0: seg = 8'h03;
      4'h1: seg = 8'h9F;
      4'h2: seg = 8'h25;
      4'h3: seg = 8'h0D;
      4'h4: seg = 8'h99;
      4'h5: seg = 8'h49;
      4'h6: seg = 8'h41;
      4'h7: seg = 8'h1F;
      4'h8: seg = 8'h01;
      4'h9: seg = 8'h09;
      4'hA: seg = 8'h11;
      4'hB: seg = 8'hC1;
      4'hC: seg = 8'h63;
      4'hD: seg = 8'h85;
      4'hE: seg = 8'h61;
      default: seg = 8'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/scancode_ascii.sv
// Set-2 make code to lower-case ASCII for a-z and 0-9; anything else maps to 8'h00.
// Purely combinational, zero latency, no flow control.
module scancode_ascii (
  input  logic [7:0] code_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    ascii_o = 8'h00;
    case (code_i)
      8'h1C: ascii_o = 8'h61;
      8'h32: ascii_o = 8'h62;
      8'h21: ascii_o = 8'h63;
      8'h23: ascii_o = 8'h64;
      8'h24: ascii_o = 8'h65;
      8'h2B: ascii_o = 8'h66;
      8'h34: ascii_o = 8'h67;
      8'h33: ascii_o = 8'h68;
      8'h43: ascii_o = 8'h69;
      8'h3B: ascii_o = 8'h6A;
      8'h42: ascii_o = 8'h6B;
      8'h4B: ascii_o = 8'h6C;
      8'h3A: ascii_o = 8'h6D;
      8'h31: ascii_o = 8'h6E;
      8'h44: ascii_o = 8'h6F;
      8'h4D: ascii_o = 8'h70;
      8'h15: ascii_o = 8'h71;
      8'h2D: ascii_o = 8'h72;
      8'h1B: ascii_o = 8'h73;
      8'h2C: ascii_o = 8'h74;
      8'h3C: ascii_o = 8'h75;
      8'h2A: ascii_o = 8'h76;
      8'h1D: ascii_o = 8'h77;
      8'h22: ascii_o = 8'h78;
      8'h35: ascii_o = 8'h79;
      8'h1A: ascii_o = 8'h7A;
      8'h45: ascii_o = 8'h30;
      8'h16: ascii_o = 8'h31;
      8'h1E: ascii_o = 8'h32;
      8'h26: ascii_o = 8'h33;
      8'h25: ascii_o = 8'h34;
      8'h2E: ascii_o = 8'h35;
      8'h36: ascii_o = 8'h36;
      8'h3D: ascii_o = 8'h37;
      8'h3E: ascii_o = 8'h38;
      8'h46: ascii_o = 8'h39;
      default: ascii_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_seg_disp.sv
// Pops PS/2 scan codes from the keyboard FIFO and shows held key, its ASCII and a press count.
// One pop every 3 cycles at most (IDLE/POP/GAP); byte processed 2 edges after the sample, display 1 edge later.
module kbd_seg_disp
  import kbd_pkg::*;
#(
  parameter bit BLANK_IDLE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] kbd_data,
  input  logic       kbd_ready,
  input  logic       kbd_overflow,
  output logic       kbd_nextdata_n,
  output logic [7:0] seg0,
  output logic [7:0] seg1,
  output logic [7:0] seg2,
  output logic [7:0] seg3,
  output logic [7:0] seg4,
  output logic [7:0] seg5,
  output logic [7:0] seg6,
  output logic [7:0] seg7,
  output logic       ovf
);

  localparam logic [7:0] SEG_IDLE = BLANK_IDLE ? SEG_BLANK : SEG_ZERO;

  pop_state_e       state_q, state_d;
  logic             nextdata_n_q, nextdata_n_d;
  logic [7:0]       byte_q, byte_d;
  logic             held_q, held_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             held_ext_q, held_ext_d;
  logic [7:0]       count_q, count_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             ovf_q, ovf_d;
  logic [7:0][7:0]  seg_q, seg_d;
  logic             proc_en;
  logic [7:0]       ascii_raw;
  logic [7:0]       ascii_eff;
  logic             blank;

  scancode_ascii u_ascii (
    .code_i  (held_code_q),
    .ascii_o (ascii_raw)
  );

  always_comb begin
    state_d      = state_q;
    nextdata_n_d = 1'b1;
    byte_d       = byte_q;
    proc_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (kbd_ready) begin
          state_d      = POP;
          byte_d       = kbd_data;
          nextdata_n_d = 1'b0;
        end
      end
      POP: state_d = GAP;
      GAP: begin
        state_d = IDLE;
        proc_en = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    held_d      = held_q;
    held_code_d = held_code_q;
    held_ext_d  = held_ext_q;
    count_d     = count_q;
    brk_d       = brk_q;
    ext_d       = ext_q;
    if (proc_en) begin
      if (byte_q == BREAK_CODE) begin
        brk_d = 1'b1;
      end else if (byte_q == EXT_CODE) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (brk_q) begin
          if (byte_q == held_code_q) held_d = 1'b0;
        end else if (!held_q || (byte_q != held_code_q)) begin
          // A repeat of the held key is typematic and does not count.
          held_d      = 1'b1;
          held_code_d = byte_q;
          held_ext_d  = ext_q;
          count_d     = count_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    ascii_eff = held_ext_q ? 8'h00 : ascii_raw;
    blank     = BLANK_IDLE && !held_q;
    seg_d[0]  = blank ? SEG_BLANK : hex2seg(held_code_q[3:0]);
    seg_d[1]  = blank ? SEG_BLANK : hex2seg(held_code_q[7:4]);
    seg_d[2]  = blank ? SEG_BLANK : hex2seg(ascii_eff[3:0]);
    seg_d[3]  = blank ? SEG_BLANK : hex2seg(ascii_eff[7:4]);
    seg_d[4]  = hex2seg(count_q[3:0]);
    seg_d[5]  = hex2seg(count_q[7:4]);
    seg_d[6]  = SEG_BLANK;
    seg_d[7]  = SEG_BLANK;
    ovf_d     = ovf_q | kbd_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      nextdata_n_q <= 1'b1;
      byte_q       <= 8'h00;
      held_q       <= 1'b0;
      held_code_q  <= 8'h00;
      held_ext_q   <= 1'b0;
      count_q      <= 8'h00;
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      ovf_q        <= 1'b0;
      seg_q        <= {SEG_BLANK, SEG_BLANK, SEG_ZERO, SEG_ZERO,
                       SEG_IDLE, SEG_IDLE, SEG_IDLE, SEG_IDLE};
    end else begin
      state_q      <= state_d;
      nextdata_n_q <= nextdata_n_d;
      byte_q       <= byte_d;
      held_q       <= held_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      count_q      <= count_d;
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      ovf_q        <= ovf_d;
      seg_q        <= seg_d;
    end
  end

  assign kbd_nextdata_n = nextdata_n_q;
  assign ovf            = ovf_q;
  assign seg0           = seg_q[0];
  assign seg1           = seg_q[1];
  assign seg2           = seg_q[2];
  assign seg3           = seg_q[3];
  assign seg4           = seg_q[4];
  assign seg5           = seg_q[5];
  assign seg6           = seg_q[6];
  assign seg7           = seg_q[7];

endmodule

// File: tb/tb_kbd_seg_disp.sv
// Bench for kbd_seg_disp: a queue models the keyboard FIFO, per-byte vector table plus timing/reset/overflow/wrap sequences.
module tb_kbd_seg_disp;

  logic       clk;
  logic       rst;
  logic [7:0] kbd_data;
  logic       kbd_ready;
  logic       kbd_overflow;
  logic       kbd_nextdata_n;
  logic [7:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7;
  logic       ovf;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [7:0] fifo_q[$];
  int         pulses[$];

  localparam logic [63:0] RESET_SEGS = 64'hFFFF_0303_FFFF_FFFF;

  typedef struct {
    logic [7:0]  code;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[17];

  kbd_seg_disp #(.BLANK_IDLE(1'b1)) dut (
    .clk            (clk),
    .rst            (rst),
    .kbd_data       (kbd_data),
    .kbd_ready      (kbd_ready),
    .kbd_overflow   (kbd_overflow),
    .kbd_nextdata_n (kbd_nextdata_n),
    .seg0           (seg0),
    .seg1           (seg1),
    .seg2           (seg2),
    .seg3           (seg3),
    .seg4           (seg4),
    .seg5           (seg5),
    .seg6           (seg6),
    .seg7           (seg7),
    .ovf            (ovf)
  );

  wire [63:0] segs = {seg7, seg6, seg5, seg4, seg3, seg2, seg1, seg0};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // FIFO model: pops on the strobe, presents the new head before the next rising edge.
  initial begin
    logic [7:0] tmp;
    kbd_ready = 1'b0;
    kbd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (kbd_nextdata_n === 1'b0) begin
        pulses.push_back(cyc);
        if (fifo_q.size() > 0) tmp = fifo_q.pop_front();
      end
      kbd_ready = (fifo_q.size() > 0);
      kbd_data  = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (fifo_q.size() > 0 && n < 2000) begin
      @(negedge clk);
      n = n + 1;
    end
    if (fifo_q.size() > 0) check({name, "_drain_timeout"}, 64'(fifo_q.size()), 64'd0);
    repeat (5) @(negedge clk);
  endtask

  task automatic do_reset();
    fifo_q.delete();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    vecs[0]  = '{8'h1C, 64'hFFFF_039F_419F_9F63};
    vecs[1]  = '{8'h1C, 64'hFFFF_039F_419F_9F63};
    vecs[2]  = '{8'h1C, 64'hFFFF_039F_419F_9F63};
    vecs[3]  = '{8'hF0, 64'hFFFF_039F_419F_9F63};
    vecs[4]  = '{8'h1C, 64'hFFFF_039F_FFFF_FFFF};
    vecs[5]  = '{8'h1C, 64'hFFFF_0325_419F_9F63};
    vecs[6]  = '{8'h16, 64'hFFFF_030D_0D9F_9F41};
    vecs[7]  = '{8'hF0, 64'hFFFF_030D_0D9F_9F41};
    vecs[8]  = '{8'h1C, 64'hFFFF_030D_0D9F_9F41};
    vecs[9]  = '{8'hE0, 64'hFFFF_030D_0D9F_9F41};
    vecs[10] = '{8'h75, 64'hFFFF_0399_0303_1F49};
    vecs[11] = '{8'hE0, 64'hFFFF_0399_0303_1F49};
    vecs[12] = '{8'hF0, 64'hFFFF_0399_0303_1F49};
    vecs[13] = '{8'h75, 64'hFFFF_0399_FFFF_FFFF};
    vecs[14] = '{8'h45, 64'hFFFF_0349_0D03_9949};
    vecs[15] = '{8'h66, 64'hFFFF_0341_0303_4141};
    vecs[16] = '{8'h4D, 64'hFFFF_031F_1F03_9985};

    rst          = 1'b1;
    kbd_overflow = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_segs", segs, RESET_SEGS);
    check("reset_nextdata_n", 64'(kbd_nextdata_n), 64'd1);
    check("reset_ovf", 64'(ovf), 64'd0);

    for (int i = 0; i < 17; i++) begin
      fifo_q.push_back(vecs[i].code);
      drain("vec");
      check($sformatf("vec%0d_code%h", i, vecs[i].code), segs, vecs[i].exp);
    end

    // Back-to-back bytes: strobe spacing and width.
    do_reset();
    pulses.delete();
    fifo_q.push_back(8'h32);
    fifo_q.push_back(8'hF0);
    fifo_q.push_back(8'h32);
    fifo_q.push_back(8'h21);
    drain("burst");
    check("burst_pulse_count", 64'(pulses.size()), 64'd4);
    for (int i = 1; i < pulses.size(); i++)
      check($sformatf("burst_pulse_gap%0d", i), 64'(pulses[i] - pulses[i-1]), 64'd3);
    check("burst_segs", segs, 64'hFFFF_0325_410D_259F);

    // Reset while the FSM sits in POP drops the latched byte.
    fifo_q.push_back(8'h1C);
    n = 0;
    do begin
      @(negedge clk);
      n = n + 1;
    end while (kbd_nextdata_n !== 1'b0 && n < 50);
    check("pop_wait_strobe", 64'(kbd_nextdata_n), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("pop_reset_nextdata_n", 64'(kbd_nextdata_n), 64'd1);
    repeat (6) @(negedge clk);
    check("pop_reset_segs", segs, RESET_SEGS);

    // Sticky overflow.
    kbd_overflow = 1'b1;
    @(negedge clk);
    kbd_overflow = 1'b0;
    @(negedge clk);
    check("ovf_set", 64'(ovf), 64'd1);
    repeat (10) @(negedge clk);
    check("ovf_sticky", 64'(ovf), 64'd1);
    do_reset();
    check("ovf_cleared", 64'(ovf), 64'd0);

    // 256 alternating makes wrap the count to 00; last held key is 32 ('b').
    for (int i = 0; i < 256; i++) fifo_q.push_back((i % 2 == 0) ? 8'h1C : 8'h32);
    drain("wrap");
    check("wrap_segs", segs, 64'hFFFF_0303_4125_0D25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
